// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the RV32I ALU issue controller: opcodes, FSM states,
// instruction classes and the packed ALU control bundle.
package alu_ctrl_pkg;

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_EXEC    = 2'd1,
      ST_CAPTURE = 2'd2
   } state_e;

   typedef enum logic [3:0] {
      CLS_ILLEGAL = 4'd0,
      CLS_ALU_IMM = 4'd1,
      CLS_ALU_REG = 4'd2,
      CLS_CB      = 4'd3,
      CLS_JAL     = 4'd4,
      CLS_JALR    = 4'd5,
      CLS_LUI     = 4'd6,
      CLS_AUIPC   = 4'd7,
      CLS_MEM     = 4'd8
   } cls_e;

   typedef struct packed {
      logic       lup;
      logic       ub;
      logic       cb;
      logic       mem;
      logic       alu_imm;
      logic       alu_reg;
      logic       iop;
      logic       fc;
      logic [2:0] fcs;
   } alu_ctrl_t;

   function automatic logic writes_rd(input cls_e cls);
      logic w;
      case (cls)
         CLS_ALU_IMM, CLS_ALU_REG, CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR: w = 1'b1;
         default:                                                         w = 1'b0;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/rv32i_imm_gen.sv
// Combinational RV32I immediate generator: picks the immediate the ALU
// expects for the instruction's class, zero for classes with none.
module rv32i_imm_gen
   import alu_ctrl_pkg::*;
(
   input  logic [31:0] instr,
   output logic [31:0] imm
);

   // LUI deliberately delivers the raw 20-bit field right-aligned; AUIPC gets it shifted.
   always_comb begin
      imm = 32'd0;
      case (instr[6:0])
         OPC_OP_IMM, OPC_JALR: imm = {{20{instr[31]}}, instr[31:20]};
         OPC_BRANCH:           imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         OPC_JAL:              imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         OPC_LUI:              imm = {12'd0, instr[31:12]};
         OPC_AUIPC:            imm = {instr[31:12], 12'd0};
         default:              imm = 32'd0;
      endcase
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Three-cycle RV32I issue controller: accept/decode, drive one ALU block for a
// cycle, then capture writeback, redirect and retirement.
module alu_issue_ctrl
   import alu_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [31:0] instr,
   input  logic [31:0] instr_pc,
   output logic [4:0]  rs1_addr,
   output logic [4:0]  rs2_addr,
   output logic        LUP,
   output logic        UB,
   output logic        CB,
   output logic        MEM,
   output logic        ALU_IMM,
   output logic        ALU_REG,
   output logic        IOP,
   output logic        FC,
   output logic [2:0]  finite_control_sig,
   output logic [31:0] port2_imm,
   output logic [31:0] program_counter,
   input  logic [31:0] port3_output,
   input  logic [31:0] pc_out,
   input  logic        pc_load,
   output logic        rd_we,
   output logic [4:0]  rd_addr,
   output logic [31:0] rd_data,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        illegal_instr,
   output logic [31:0] retired_count
);

   state_e      state_q;
   cls_e        cls_q, cls_d;
   alu_ctrl_t   ctrl_q, ctrl_d;
   logic [31:0] imm_d, imm_q, pc_q;
   logic [4:0]  rs1_q, rs2_q, rs2_d, rd_q;
   logic        ready_q, rd_we_q, redir_q, illegal_q;
   logic [4:0]  rd_addr_q;
   logic [31:0] rd_data_q, redir_pc_q, retired_q;
   logic [2:0]  funct3_s;

   rv32i_imm_gen u_imm_gen (
      .instr (instr),
      .imm   (imm_d)
   );

   // Decode the offered instruction into class, ALU controls and rs2 routing.
   always_comb begin
      funct3_s = instr[14:12];
      cls_d    = CLS_ILLEGAL;
      ctrl_d   = '0;
      case (instr[6:0])
         OPC_OP_IMM:          cls_d = CLS_ALU_IMM;
         OPC_OP:              cls_d = CLS_ALU_REG;
         OPC_BRANCH:          cls_d = CLS_CB;
         OPC_JAL:             cls_d = CLS_JAL;
         OPC_JALR:            cls_d = CLS_JALR;
         OPC_LUI:             cls_d = CLS_LUI;
         OPC_AUIPC:           cls_d = CLS_AUIPC;
         OPC_LOAD, OPC_STORE: cls_d = CLS_MEM;
         default:             cls_d = CLS_ILLEGAL;
      endcase
      case (cls_d)
         CLS_ALU_IMM: begin
            ctrl_d.alu_imm = 1'b1;
            ctrl_d.fcs     = funct3_s;
            ctrl_d.iop     = (funct3_s == 3'b101) ? instr[30] : 1'b0;
         end
         CLS_ALU_REG: begin
            ctrl_d.alu_reg = 1'b1;
            ctrl_d.fcs     = funct3_s;
            ctrl_d.iop     = ((funct3_s == 3'b000) || (funct3_s == 3'b101)) ? instr[30] : 1'b0;
         end
         CLS_CB: begin
            ctrl_d.cb  = 1'b1;
            ctrl_d.fcs = funct3_s;
         end
         CLS_JAL: begin
            ctrl_d.ub  = 1'b1;
            ctrl_d.fcs = 3'b010;
         end
         CLS_JALR: begin
            ctrl_d.ub  = 1'b1;
            ctrl_d.fcs = 3'b011;
         end
         CLS_LUI: begin
            ctrl_d.lup = 1'b1;
            ctrl_d.iop = 1'b1;
         end
         CLS_AUIPC: ctrl_d.lup = 1'b1;
         CLS_MEM:   ctrl_d.mem = 1'b1;
         default:   ctrl_d     = '0;
      endcase
      rs2_d = (cls_d == CLS_JALR) ? instr[19:15] : instr[24:20];
   end

   // Issue FSM with all outputs held in registers; pulses last exactly one CAPTURE cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cls_q      <= CLS_ILLEGAL;
         ctrl_q     <= '0;
         imm_q      <= 32'd0;
         pc_q       <= 32'd0;
         rs1_q      <= 5'd0;
         rs2_q      <= 5'd0;
         rd_q       <= 5'd0;
         ready_q    <= 1'b0;
         rd_we_q    <= 1'b0;
         rd_addr_q  <= 5'd0;
         rd_data_q  <= 32'd0;
         redir_q    <= 1'b0;
         redir_pc_q <= 32'd0;
         illegal_q  <= 1'b0;
         retired_q  <= 32'd0;
      end else begin
         rd_we_q   <= 1'b0;
         redir_q   <= 1'b0;
         illegal_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (instr_valid && ready_q) begin
                  cls_q   <= cls_d;
                  ctrl_q  <= ctrl_d;
                  imm_q   <= imm_d;
                  pc_q    <= instr_pc;
                  rs1_q   <= instr[19:15];
                  rs2_q   <= rs2_d;
                  rd_q    <= instr[11:7];
                  ready_q <= 1'b0;
                  state_q <= ST_EXEC;
               end else begin
                  ready_q <= 1'b1;
               end
            end
            ST_EXEC: begin
               ctrl_q    <= '0;
               retired_q <= retired_q + 32'd1;
               state_q   <= ST_CAPTURE;
               if (writes_rd(cls_q) && (rd_q != 5'd0)) begin
                  rd_we_q   <= 1'b1;
                  rd_addr_q <= rd_q;
                  rd_data_q <= ((cls_q == CLS_JAL) || (cls_q == CLS_JALR)) ? (pc_q + 32'd4) : port3_output;
               end
               if ((cls_q == CLS_JAL) || (cls_q == CLS_JALR) || ((cls_q == CLS_CB) && pc_load)) begin
                  redir_q    <= 1'b1;
                  redir_pc_q <= pc_out;
               end
               illegal_q <= (cls_q == CLS_ILLEGAL);
            end
            ST_CAPTURE: begin
               ready_q <= 1'b1;
               state_q <= ST_IDLE;
            end
            default: begin
               ready_q <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign instr_ready        = ready_q;
   assign rs1_addr           = rs1_q;
   assign rs2_addr           = rs2_q;
   assign LUP                = ctrl_q.lup;
   assign UB                 = ctrl_q.ub;
   assign CB                 = ctrl_q.cb;
   assign MEM                = ctrl_q.mem;
   assign ALU_IMM            = ctrl_q.alu_imm;
   assign ALU_REG            = ctrl_q.alu_reg;
   assign IOP                = ctrl_q.iop;
   assign FC                 = ctrl_q.fc;
   assign finite_control_sig = ctrl_q.fcs;
   assign port2_imm          = imm_q;
   assign program_counter    = pc_q;
   assign rd_we              = rd_we_q;
   assign rd_addr            = rd_addr_q;
   assign rd_data            = rd_data_q;
   assign redirect_valid     = redir_q;
   assign redirect_pc        = redir_pc_q;
   assign illegal_instr      = illegal_q;
   assign retired_count      = retired_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: hand-encoded RV32I words with
// hand-computed decode, writeback, redirect and retirement expectations.
module tb_alu_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr, instr_pc;
   logic [4:0]  rs1_addr, rs2_addr;
   logic        LUP, UB, CB, MEM, ALU_IMM, ALU_REG, IOP, FC;
   logic [2:0]  finite_control_sig;
   logic [31:0] port2_imm, program_counter;
   logic [31:0] port3_output, pc_out;
   logic        pc_load;
   logic        rd_we;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        illegal_instr;
   logic [31:0] retired_count;
   logic [7:0]  sel_s;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] exp_ret = 32'd0;

   always #5 clk = ~clk;

   assign sel_s = {LUP, UB, CB, MEM, ALU_IMM, ALU_REG, IOP, FC};

   alu_issue_ctrl dut (
      .clk                (clk),
      .rst                (rst),
      .instr_valid        (instr_valid),
      .instr_ready        (instr_ready),
      .instr              (instr),
      .instr_pc           (instr_pc),
      .rs1_addr           (rs1_addr),
      .rs2_addr           (rs2_addr),
      .LUP                (LUP),
      .UB                 (UB),
      .CB                 (CB),
      .MEM                (MEM),
      .ALU_IMM            (ALU_IMM),
      .ALU_REG            (ALU_REG),
      .IOP                (IOP),
      .FC                 (FC),
      .finite_control_sig (finite_control_sig),
      .port2_imm          (port2_imm),
      .program_counter    (program_counter),
      .port3_output       (port3_output),
      .pc_out             (pc_out),
      .pc_load            (pc_load),
      .rd_we              (rd_we),
      .rd_addr            (rd_addr),
      .rd_data            (rd_data),
      .redirect_valid     (redirect_valid),
      .redirect_pc        (redirect_pc),
      .illegal_instr      (illegal_instr),
      .retired_count      (retired_count)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full accept/EXEC/CAPTURE pass; ALU results are presented during EXEC.
   task automatic do_instr(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                           input logic [31:0] p3, input logic [31:0] pco, input logic pld,
                           input logic [7:0] e_sel, input logic [2:0] e_fcs, input logic [31:0] e_imm,
                           input logic [4:0] e_rs1, input logic [4:0] e_rs2,
                           input logic e_we, input logic [4:0] e_rd, input logic [31:0] e_rdata,
                           input logic e_redir, input logic [31:0] e_rpc, input logic e_ill);
      chk({tag, "/ready_idle"}, {31'd0, instr_ready}, 32'd1);
      instr_valid = 1'b1;
      instr       = ins;
      instr_pc    = pc;
      tick();
      instr_valid = 1'b0;
      instr       = 32'h0000_0013;
      chk({tag, "/ready_exec"}, {31'd0, instr_ready}, 32'd0);
      chk({tag, "/sel_exec"}, {24'd0, sel_s}, {24'd0, e_sel});
      chk({tag, "/fcs"}, {29'd0, finite_control_sig}, {29'd0, e_fcs});
      chk({tag, "/imm"}, port2_imm, e_imm);
      chk({tag, "/rs1"}, {27'd0, rs1_addr}, {27'd0, e_rs1});
      chk({tag, "/rs2"}, {27'd0, rs2_addr}, {27'd0, e_rs2});
      chk({tag, "/pc"}, program_counter, pc);
      chk({tag, "/we_exec"}, {31'd0, rd_we}, 32'd0);
      port3_output = p3;
      pc_out       = pco;
      pc_load      = pld;
      tick();
      chk({tag, "/sel_cap"}, {24'd0, sel_s}, 32'd0);
      chk({tag, "/we"}, {31'd0, rd_we}, {31'd0, e_we});
      if (e_we) begin
         chk({tag, "/rd_addr"}, {27'd0, rd_addr}, {27'd0, e_rd});
         chk({tag, "/rd_data"}, rd_data, e_rdata);
      end
      chk({tag, "/redir"}, {31'd0, redirect_valid}, {31'd0, e_redir});
      if (e_redir) begin
         chk({tag, "/redir_pc"}, redirect_pc, e_rpc);
      end
      chk({tag, "/illegal"}, {31'd0, illegal_instr}, {31'd0, e_ill});
      exp_ret = exp_ret + 32'd1;
      chk({tag, "/retired"}, retired_count, exp_ret);
      chk({tag, "/imm_hold"}, port2_imm, e_imm);
      chk({tag, "/rs2_hold"}, {27'd0, rs2_addr}, {27'd0, e_rs2});
      chk({tag, "/pc_hold"}, program_counter, pc);
      tick();
      pc_load = 1'b0;
      chk({tag, "/pulses_off"}, {29'd0, rd_we, redirect_valid, illegal_instr}, 32'd0);
      chk({tag, "/ready_back"}, {31'd0, instr_ready}, 32'd1);
   endtask

   initial begin
      logic [8:0] we_mask;
      rst          = 1'b1;
      instr_valid  = 1'b0;
      instr        = 32'd0;
      instr_pc     = 32'd0;
      port3_output = 32'd0;
      pc_out       = 32'd0;
      pc_load      = 1'b0;
      tick();
      tick();
      chk("rst/ready", {31'd0, instr_ready}, 32'd0);
      chk("rst/sel", {24'd0, sel_s}, 32'd0);
      chk("rst/pulses", {29'd0, rd_we, redirect_valid, illegal_instr}, 32'd0);
      chk("rst/retired", retired_count, 32'd0);
      chk("rst/pc", program_counter, 32'd0);
      rst = 1'b0;
      chk("rst/ready_still_low", {31'd0, instr_ready}, 32'd0);
      tick();
      chk("rst/ready_rise", {31'd0, instr_ready}, 32'd1);

      //         tag      instr         pc            p3            pc_out        pld   sel          fcs     imm           rs1    rs2    we    rd     rdata         redir rpc           ill
      do_instr("addi",  32'hFFF00293, 32'h0000_0080, 32'hFFFF_FFFF, 32'h0,        1'b0, 8'b0000_1000, 3'b000, 32'hFFFF_FFFF, 5'd0,  5'd31, 1'b1, 5'd5,  32'hFFFF_FFFF, 1'b0, 32'h0,        1'b0);
      do_instr("beq_t", 32'h00208863, 32'h0000_0100, 32'h1234_5678, 32'h0000_0110, 1'b1, 8'b0010_0000, 3'b000, 32'h0000_0010, 5'd1,  5'd2,  1'b0, 5'd0,  32'h0,        1'b1, 32'h0000_0110, 1'b0);
      do_instr("beq_n", 32'h00208863, 32'h0000_0100, 32'h1234_5678, 32'h0000_0110, 1'b0, 8'b0010_0000, 3'b000, 32'h0000_0010, 5'd1,  5'd2,  1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0);
      do_instr("jalr",  32'h008180E7, 32'h0000_0200, 32'hDEAD_BEEF, 32'h3000_0008, 1'b0, 8'b0100_0000, 3'b011, 32'h0000_0008, 5'd3,  5'd3,  1'b1, 5'd1,  32'h0000_0204, 1'b1, 32'h3000_0008, 1'b0);
      do_instr("add_x0",32'h00208033, 32'h0000_0300, 32'h0000_0055, 32'h0,        1'b1, 8'b0000_0100, 3'b000, 32'h0,        5'd1,  5'd2,  1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0);
      do_instr("illeg", 32'h0000007F, 32'h0000_0304, 32'h0000_0001, 32'h0000_0999, 1'b1, 8'b0000_0000, 3'b000, 32'h0,        5'd0,  5'd0,  1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        1'b1);
      do_instr("sub",   32'h402081B3, 32'h0000_0308, 32'hFFFF_FFF0, 32'h0,        1'b0, 8'b0000_0110, 3'b000, 32'h0,        5'd1,  5'd2,  1'b1, 5'd3,  32'hFFFF_FFF0, 1'b0, 32'h0,        1'b0);
      do_instr("srai",  32'h40435393, 32'h0000_030C, 32'h0000_0ABC, 32'h0,        1'b0, 8'b0000_1010, 3'b101, 32'h0000_0404, 5'd6,  5'd4,  1'b1, 5'd7,  32'h0000_0ABC, 1'b0, 32'h0,        1'b0);
      do_instr("lui",   32'h12345537, 32'h0000_0310, 32'h1234_5000, 32'h0,        1'b0, 8'b1000_0010, 3'b000, 32'h0001_2345, 5'd8,  5'd3,  1'b1, 5'd10, 32'h1234_5000, 1'b0, 32'h0,        1'b0);
      do_instr("auipc", 32'hABCDE597, 32'h0000_0314, 32'hABCD_E314, 32'h0,        1'b1, 8'b1000_0000, 3'b000, 32'hABCD_E000, 5'd27, 5'd28, 1'b1, 5'd11, 32'hABCD_E314, 1'b0, 32'h0,        1'b0);
      do_instr("jal_wr",32'hFFDFF0EF, 32'hFFFF_FFFC, 32'h5555_5555, 32'hFFFF_FFF8, 1'b0, 8'b0100_0000, 3'b010, 32'hFFFF_FFFC, 5'd31, 5'd29, 1'b1, 5'd1,  32'h0000_0000, 1'b1, 32'hFFFF_FFF8, 1'b0);
      do_instr("lw",    32'h0000A283, 32'h0000_0400, 32'h0000_0077, 32'h0000_0888, 1'b1, 8'b0001_0000, 3'b000, 32'h0,        5'd1,  5'd0,  1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0);

      // Reset in the middle of an instruction: abort without writeback or count.
      instr_valid = 1'b1;
      instr       = 32'h00500313;
      instr_pc    = 32'h0000_0500;
      tick();
      instr_valid = 1'b0;
      chk("abort/in_exec", {24'd0, sel_s}, 32'h0000_0008);
      rst          = 1'b1;
      port3_output = 32'h0000_0005;
      tick();
      chk("abort/sel", {24'd0, sel_s}, 32'd0);
      chk("abort/we", {31'd0, rd_we}, 32'd0);
      chk("abort/retired", retired_count, 32'd0);
      chk("abort/ready", {31'd0, instr_ready}, 32'd0);
      chk("abort/pc", program_counter, 32'd0);
      chk("abort/imm", port2_imm, 32'd0);
      rst     = 1'b0;
      exp_ret = 32'd0;
      tick();
      chk("abort/ready_rise", {31'd0, instr_ready}, 32'd1);

      // Back-to-back: valid held high, expect writebacks on ticks 2, 5 and 8.
      instr_valid  = 1'b1;
      instr        = 32'hFFF00293;
      instr_pc     = 32'h0000_0600;
      port3_output = 32'h0000_0001;
      we_mask      = 9'd0;
      for (int i = 0; i < 9; i++) begin
         tick();
         we_mask[i] = rd_we;
      end
      instr_valid = 1'b0;
      chk("b2b/we_mask", {23'd0, we_mask}, 32'h0000_0092);
      chk("b2b/retired", retired_count, 32'd3);
      tick();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
